// File: rtl/temp_ascii_formatter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : temp_ascii_formatter_if
// Purpose  : Sample-in / UART-byte-out bundle for temp_ascii_formatter.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface temp_ascii_formatter_if;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        tx_ready;
  logic        tx_done_tick;
  logic        tx_start;
  logic [7:0]  w_data;
  logic        busy;

  // master: the formatter, which sources bytes toward the UART
  modport master (
    input  sample_valid, sample_data, tx_ready, tx_done_tick,
    output tx_start, w_data, busy
  );

  modport slave (
    output sample_valid, sample_data, tx_ready, tx_done_tick,
    input  tx_start, w_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/temp_ascii_formatter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : temp_ascii_formatter
// Purpose  : Renders one MAX31855 frame as an ASCII line ("+0025.50\r\n" or
//            "ERRn\r\n") and streams it byte by byte to a UART.
//            Optional macro HEX_RAW_EN appends " XXXXXXXX" raw hex to normal lines.
// Revision : 1.0
// ----------------------------------------------------------------------------
module temp_ascii_formatter #(
  parameter bit CRLF      = 1'b1,
  parameter bit SIGN_PLUS = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  temp_ascii_formatter_if.master bus
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_CONVERT   = 2'd1;
  localparam logic [1:0] S_SEND      = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam logic [4:0] EOL_LEN     = CRLF ? 5'd2 : 5'd1;
`ifdef HEX_RAW_EN
  localparam logic [4:0] NORM_BODY   = 5'd17;
`else
  localparam logic [4:0] NORM_BODY   = 5'd8;
`endif
  localparam logic [4:0] FAULT_BODY  = 5'd4;
  localparam logic [3:0] DABBLE_LAST = 4'd12;
  localparam logic [7:0] CH_POS_SIGN = SIGN_PLUS ? 8'h2B : 8'h20;

  logic [1:0]  state_q, state_d;
  logic        busy_q, busy_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  w_data_q, w_data_d;
  logic [4:0]  idx_q, idx_d;
  logic        fault_q, fault_d;
  logic [2:0]  code_q, code_d;
  logic        neg_q, neg_d;
  logic [1:0]  frac_q, frac_d;
  logic [12:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [14:0] w_temp15;
  logic [14:0] w_mag;
  logic [11:0] w_bcd_adj;
  logic [4:0]  w_body_len;
  logic [4:0]  w_last_idx;
  logic [7:0]  w_frac_hi;
  logic [7:0]  w_hex_byte;
  logic [7:0]  w_byte;

  // 15 bits so that -8192 negates to an exact 8192
  assign w_temp15 = {bus.sample_data[31], bus.sample_data[31:18]};
  assign w_mag    = bus.sample_data[31] ? (15'd0 - w_temp15) : w_temp15;

  // Top digit never reaches 5 before the final shift (int <= 2048), so only
  // the lower three digits need the add-3 correction.
  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dabble
      assign w_bcd_adj[4*g +: 4] = (bcd_q[4*g +: 4] >= 4'd5) ?
                                   (bcd_q[4*g +: 4] + 4'd3) : bcd_q[4*g +: 4];
    end
  endgenerate

  assign w_body_len = fault_q ? FAULT_BODY : NORM_BODY;
  assign w_last_idx = w_body_len + EOL_LEN - 5'd1;

  always_comb begin
    case (frac_q)
      2'd0:    w_frac_hi = 8'h30;
      2'd1:    w_frac_hi = 8'h32;
      2'd2:    w_frac_hi = 8'h35;
      default: w_frac_hi = 8'h37;
    endcase
  end

`ifdef HEX_RAW_EN
  logic [31:0] raw_q, raw_d;
  logic [2:0]  w_hex_pos;
  logic [3:0]  w_nib;

  assign w_hex_pos = 3'(idx_q - 5'd9);
  assign w_nib     = 4'(raw_q >> {~w_hex_pos, 2'b00});

  always_comb begin
    if (idx_q == 5'd8)
      w_hex_byte = 8'h20;
    else if (w_nib < 4'd10)
      w_hex_byte = {4'h3, w_nib};
    else
      w_hex_byte = 8'h37 + {4'h0, w_nib};
  end
`else
  logic w_unused;
  assign w_unused   = ^{bus.sample_data[17], bus.sample_data[15:3]};
  assign w_hex_byte = 8'h00;
`endif

  always_comb begin
    w_byte = 8'h00;
    if (idx_q == w_body_len) begin
      w_byte = CRLF ? 8'h0D : 8'h0A;
    end else if (idx_q > w_body_len) begin
      w_byte = 8'h0A;
    end else if (fault_q) begin
      case (idx_q)
        5'd0:       w_byte = 8'h45;
        5'd1, 5'd2: w_byte = 8'h52;
        default:    w_byte = {5'b00110, code_q};
      endcase
    end else begin
      case (idx_q)
        5'd0:    w_byte = neg_q ? 8'h2D : CH_POS_SIGN;
        5'd1:    w_byte = {4'h3, bcd_q[15:12]};
        5'd2:    w_byte = {4'h3, bcd_q[11:8]};
        5'd3:    w_byte = {4'h3, bcd_q[7:4]};
        5'd4:    w_byte = {4'h3, bcd_q[3:0]};
        5'd5:    w_byte = 8'h2E;
        5'd6:    w_byte = w_frac_hi;
        5'd7:    w_byte = frac_q[0] ? 8'h35 : 8'h30;
        default: w_byte = w_hex_byte;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    tx_start_d = 1'b0;
    w_data_d   = w_data_q;
    idx_d      = idx_q;
    fault_d    = fault_q;
    code_d     = code_q;
    neg_d      = neg_q;
    frac_d     = frac_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
`ifdef HEX_RAW_EN
    raw_d      = raw_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.sample_valid) begin
          busy_d  = 1'b1;
          idx_d   = 5'd0;
          fault_d = bus.sample_data[16];
          code_d  = bus.sample_data[2:0];
          neg_d   = bus.sample_data[31];
          frac_d  = w_mag[1:0];
          bin_d   = w_mag[14:2];
          bcd_d   = 16'h0000;
          cnt_d   = 4'd0;
`ifdef HEX_RAW_EN
          raw_d   = bus.sample_data;
`endif
          state_d = bus.sample_data[16] ? S_SEND : S_CONVERT;
        end
      end
      S_CONVERT: begin
        bcd_d = {bcd_q[14:12], w_bcd_adj, bin_q[12]};
        bin_d = {bin_q[11:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == DABBLE_LAST)
          state_d = S_SEND;
      end
      S_SEND: begin
        w_data_d = w_byte;
        if (bus.tx_ready) begin
          tx_start_d = 1'b1;
          state_d    = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (bus.tx_done_tick) begin
          if (idx_q == w_last_idx) begin
            idx_d   = 5'd0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      w_data_q   <= 8'h00;
      idx_q      <= 5'd0;
      fault_q    <= 1'b0;
      code_q     <= 3'd0;
      neg_q      <= 1'b0;
      frac_q     <= 2'd0;
      bin_q      <= 13'd0;
      bcd_q      <= 16'h0000;
      cnt_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start_d;
      w_data_q   <= w_data_d;
      idx_q      <= idx_d;
      fault_q    <= fault_d;
      code_q     <= code_d;
      neg_q      <= neg_d;
      frac_q     <= frac_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef HEX_RAW_EN
  always_ff @(posedge clk) begin
    if (reset)
      raw_q <= 32'h0000_0000;
    else
      raw_q <= raw_d;
  end
`endif

  assign bus.tx_start = tx_start_q;
  assign bus.w_data   = w_data_q;
  assign bus.busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_temp_ascii_formatter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_temp_ascii_formatter
// Purpose  : Self-checking bench: directed and random frames against a
//            decimal-arithmetic line model, with a simple UART responder.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_temp_ascii_formatter;

  typedef byte unsigned bq_t[$];

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  temp_ascii_formatter_if u_bus0();
  temp_ascii_formatter_if u_bus1();

  temp_ascii_formatter u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_bus0)
  );

  temp_ascii_formatter #(.CRLF(1'b0), .SIGN_PLUS(1'b0)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected line straight from the frame's meaning: degrees, quarters, text.
  function automatic bq_t ref_line(input logic [31:0] raw, input bit crlf, input bit splus);
    bq_t l;
    int  t, mag, ip, fc, nib;
    l = {};
    if (raw[16]) begin
      l.push_back(8'h45); l.push_back(8'h52); l.push_back(8'h52);
      l.push_back(8'(48 + int'(raw[2:0])));
    end else begin
      t   = int'($signed(raw[31:18]));
      mag = (t < 0) ? -t : t;
      ip  = mag / 4;
      fc  = (mag % 4) * 25;
      l.push_back(t < 0 ? 8'h2D : (splus ? 8'h2B : 8'h20));
      l.push_back(8'(48 + ip / 1000));
      l.push_back(8'(48 + (ip / 100) % 10));
      l.push_back(8'(48 + (ip / 10) % 10));
      l.push_back(8'(48 + ip % 10));
      l.push_back(8'h2E);
      l.push_back(8'(48 + fc / 10));
      l.push_back(8'(48 + fc % 10));
`ifdef HEX_RAW_EN
      l.push_back(8'h20);
      for (int k = 7; k >= 0; k--) begin
        nib = int'((raw >> (4 * k)) & 32'hF);
        l.push_back(8'(nib < 10 ? 48 + nib : 55 + nib));
      end
`endif
    end
    if (crlf) l.push_back(8'h0D);
    l.push_back(8'h0A);
    return l;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // UART responder for DUT0: ready drops on tx_start, done pulses dly0 cycles later
  logic        rdy0  = 1'b1;
  logic        hold0 = 1'b0;
  logic        done0 = 1'b0;
  logic        spur0 = 1'b0;
  int          cnt0  = 0;
  int          dly0  = 3;
  int          first_start0 = -1;
  int          last_done0   = 0;
  byte unsigned cap0[$];
  byte unsigned last0 = 8'h00;

  assign u_bus0.tx_ready     = rdy0 & ~hold0;
  assign u_bus0.tx_done_tick = done0 | spur0;

  always @(negedge clk) begin
    if (u_bus0.tx_start === 1'b1) begin
      chk("start_gap", 32'(u_bus0.tx_done_tick), 32'd0);
      cap0.push_back(u_bus0.w_data);
      last0 = u_bus0.w_data;
      rdy0  = 1'b0;
      cnt0  = dly0;
      done0 = 1'b0;
      if (first_start0 < 0) first_start0 = cyc;
    end else if (cnt0 > 0) begin
      if (u_bus0.busy === 1'b1) chk("wdata_hold", 32'(u_bus0.w_data), 32'(last0));
      cnt0--;
      done0 = (cnt0 == 0);
      if (cnt0 == 0) begin
        rdy0       = 1'b1;
        last_done0 = cyc;
      end
    end else begin
      done0 = 1'b0;
    end
  end

  // Fixed-delay responder for DUT1
  logic        done1 = 1'b0;
  int          cnt1  = 0;
  byte unsigned cap1[$];

  assign u_bus1.tx_ready     = (cnt1 == 0);
  assign u_bus1.tx_done_tick = done1;

  always @(negedge clk) begin
    if (u_bus1.tx_start === 1'b1) begin
      cap1.push_back(u_bus1.w_data);
      cnt1  = 2;
      done1 = 1'b0;
    end else if (cnt1 > 0) begin
      cnt1--;
      done1 = (cnt1 == 0);
    end else begin
      done1 = 1'b0;
    end
  end

  // mode 0: plain, 1: stall tx_ready 50 cycles after byte 3, 2: poke while busy
  task automatic run_line0(input logic [31:0] raw, input string tag, input int mode);
    bq_t          exp;
    int           a, n, n0;
    bit           held;
    logic [7:0]   wd;
    exp = ref_line(raw, 1'b1, 1'b1);
    cap0.delete();
    first_start0 = -1;
    held = 1'b0;
    wd   = 8'h00;
    u_bus0.sample_data  = raw;
    u_bus0.sample_valid = 1'b1;
    a = cyc;
    @(negedge clk);
    u_bus0.sample_valid = 1'b0;
    chk({tag, "_busy_on"}, 32'(u_bus0.busy), 32'd1);
    if (mode == 2) begin
      u_bus0.sample_data  = 32'h0000_0000;
      u_bus0.sample_valid = 1'b1;
      spur0 = 1'b1;
      @(negedge clk);
      u_bus0.sample_valid = 1'b0;
      spur0 = 1'b0;
    end
    n = 0;
    while (u_bus0.busy === 1'b1 && n < 3000) begin
      if (mode == 1 && !held && cap0.size() == 3) begin
        held  = 1'b1;
        hold0 = 1'b1;
        n0    = cap0.size();
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (i == 12) wd = u_bus0.w_data;
          else if (i > 12) chk({tag, "_hold_wdata"}, 32'(u_bus0.w_data), 32'(wd));
        end
        chk({tag, "_hold_nostart"}, 32'(cap0.size()), 32'(n0));
        hold0 = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_finished"}, 32'(n < 3000), 32'd1);
    chk({tag, "_busy_fall"}, 32'(cyc - last_done0), 32'd1);
    chk({tag, "_latency"}, 32'(first_start0 - a), raw[16] ? 32'd2 : 32'd15);
    chk({tag, "_len"}, 32'(cap0.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < cap0.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(cap0[i]), 32'(exp[i]));
  endtask

  task automatic run_line1(input logic [31:0] raw, input string tag);
    bq_t exp;
    int  n;
    exp = ref_line(raw, 1'b0, 1'b0);
    cap1.delete();
    u_bus1.sample_data  = raw;
    u_bus1.sample_valid = 1'b1;
    @(negedge clk);
    u_bus1.sample_valid = 1'b0;
    n = 0;
    while (u_bus1.busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_finished"}, 32'(n < 3000), 32'd1);
    chk({tag, "_len"}, 32'(cap1.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < cap1.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(cap1[i]), 32'(exp[i]));
  endtask

  task automatic rst_mid_line(input logic [31:0] raw);
    int n, n0;
    cap0.delete();
    u_bus0.sample_data  = raw;
    u_bus0.sample_valid = 1'b1;
    @(negedge clk);
    u_bus0.sample_valid = 1'b0;
    n = 0;
    while (cap0.size() < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached", 32'(n < 500), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_tx_start", 32'(u_bus0.tx_start), 32'd0);
    chk("rst_mid_w_data", 32'(u_bus0.w_data), 32'd0);
    chk("rst_mid_busy", 32'(u_bus0.busy), 32'd0);
    n0 = cap0.size();
    repeat (40) @(negedge clk);
    chk("rst_mid_no_more", 32'(cap0.size()), 32'(n0));
  endtask

  initial begin
    logic [31:0] raw;
    reset = 1'b1;
    u_bus0.sample_valid = 1'b0;
    u_bus0.sample_data  = 32'h0;
    u_bus1.sample_valid = 1'b0;
    u_bus1.sample_data  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst0_tx_start", 32'(u_bus0.tx_start), 32'd0);
    chk("rst0_w_data",   32'(u_bus0.w_data),   32'd0);
    chk("rst0_busy",     32'(u_bus0.busy),     32'd0);
    chk("rst1_tx_start", 32'(u_bus1.tx_start), 32'd0);
    chk("rst1_w_data",   32'(u_bus1.w_data),   32'd0);
    chk("rst1_busy",     32'(u_bus1.busy),     32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_line0(32'h0198_0000, "t1_p25_50", 0);
    run_line0(32'hFFFC_0000, "t2_m0_25", 0);
    run_line0(32'h8000_0000, "t2_m2048", 0);
    run_line0(32'h7FFC_0000, "t2_p2047_75", 0);
    run_line0(32'h0001_0001, "t3_err1", 0);
    run_line0(32'h0001_0004, "t3_err4", 0);
    dly0 = 4;
    run_line0(32'h0064_0000, "t4_stall", 1);
    run_line0(32'h0190_0000, "t5_poke", 2);
    rst_mid_line(32'h7FFC_0000);
    run_line0(32'h0000_0000, "t5_after_rst", 0);

    for (int i = 0; i < 20; i++) begin
      raw     = $urandom;
      raw[16] = ($urandom_range(0, 3) == 0);
      dly0    = $urandom_range(1, 6);
      run_line0(raw, $sformatf("rnd%0d", i), 0);
    end

    run_line1(32'h0198_0000, "p0_p25_50");
    run_line1(32'hFFFC_0000, "p0_m0_25");
    run_line1(32'h0001_0002, "p0_err2");
    for (int i = 0; i < 5; i++) begin
      raw     = $urandom;
      raw[16] = ($urandom_range(0, 2) == 0);
      run_line1(raw, $sformatf("p0_rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
